comp_2bit: RTL and testbench

Registered magnitude comparator for two WIDTH-bit operands, default 2 bits. It produces three mutually exclusive flags: greater-than, less-than and equal. It is a leaf datapath block used wherever two small unsigned codes must be ordered. Outputs are registered on the clock with one cycle of latency and a qualifying valid strobe.

---
 rtl/comp_2bit.sv | 58 +++++
 tb/tb_comp_2bit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/comp_2bit.sv
// Registered WIDTH-bit magnitude comparator (unsigned or two's complement), 1-cycle latency.
// No backpressure: one compare is accepted every cycle in_vld is high; flags hold otherwise.
module comp_2bit #(
  parameter int WIDTH  = 2,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_vld,
  output logic             a_grt_b,
  output logic             a_less_b,
  output logic             eq,
  output logic             out_vld
);

  logic grt_c;
  logic less_c;
  logic diff_found;

  // MSB-first cascade: the first differing bit decides. In a signed build a
  // differing MSB is a sign mismatch, so the operand with the set bit is smaller.
  always_comb begin
    grt_c      = 1'b0;
    less_c     = 1'b0;
    diff_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!diff_found && (a[i] != b[i])) begin
        diff_found = 1'b1;
        if ((SIGNED != 0) && (i == WIDTH - 1)) begin
          grt_c  = b[i];
          less_c = a[i];
        end else begin
          grt_c  = a[i];
          less_c = b[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_grt_b  <= 1'b0;
      a_less_b <= 1'b0;
      eq       <= 1'b0;
      out_vld  <= 1'b0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        a_grt_b  <= grt_c;
        a_less_b <= less_c;
        eq       <= !diff_found;
      end
    end
  end

endmodule

// File: tb/tb_comp_2bit.sv
// Directed bench for comp_2bit: unsigned 2-bit, signed 2-bit and unsigned 8-bit builds side by side.
module tb_comp_2bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_vld;
  logic [1:0] ua, ub;
  logic [1:0] sa, sb;
  logic [7:0] wa, wb;

  logic u_gt, u_lt, u_eq, u_vld;
  logic s_gt, s_lt, s_eq, s_vld;
  logic w_gt, w_lt, w_eq, w_vld;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  comp_2bit #(.WIDTH(2), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(ua), .b(ub), .in_vld(in_vld),
    .a_grt_b(u_gt), .a_less_b(u_lt), .eq(u_eq), .out_vld(u_vld)
  );

  comp_2bit #(.WIDTH(2), .SIGNED(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .a(sa), .b(sb), .in_vld(in_vld),
    .a_grt_b(s_gt), .a_less_b(s_lt), .eq(s_eq), .out_vld(s_vld)
  );

  comp_2bit #(.WIDTH(8), .SIGNED(0)) w_dut (
    .clk(clk), .rst_n(rst_n), .a(wa), .b(wb), .in_vld(in_vld),
    .a_grt_b(w_gt), .a_less_b(w_lt), .eq(w_eq), .out_vld(w_vld)
  );

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {gt,lt,eq,vld}=%b expected %b", tag, got, exp);
    end
  endtask

  // Advance one edge and settle; inputs change only here, 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] u_flags();
    return {u_gt, u_lt, u_eq, u_vld};
  endfunction

  // Hand-computed signed/wide vectors: {gt,lt,eq,vld} expected for each build.
  logic [1:0] s_a_tab [4] = '{2'b11, 2'b01, 2'b10, 2'b10};
  logic [1:0] s_b_tab [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
  logic [3:0] s_e_tab [4] = '{4'b0101, 4'b1001, 4'b0011, 4'b0101};
  logic [7:0] w_a_tab [4] = '{8'h80, 8'h00, 8'hFF, 8'h00};
  logic [7:0] w_b_tab [4] = '{8'h7F, 8'hFF, 8'h00, 8'h00};
  logic [3:0] w_e_tab [4] = '{4'b1001, 4'b0101, 4'b1001, 4'b0011};

  initial begin
    rst_n  = 1'b0;
    in_vld = 1'b1;
    ua = 2'd3; ub = 2'd0;
    sa = 2'd0; sb = 2'd0;
    wa = 8'd0; wb = 8'd0;

    // Reset wins over in_vld for two edges, then the held pair appears.
    step();
    chk("reset_edge0", u_flags(), 4'b0000);
    step();
    chk("reset_edge1", u_flags(), 4'b0000);
    chk("reset_wide", {w_gt, w_lt, w_eq, w_vld}, 4'b0000);
    rst_n = 1'b1;
    step();
    chk("reset_release", u_flags(), 4'b1001);

    // All 16 unsigned pairs back to back.
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        logic [3:0] exp;
        ua = ia[1:0];
        ub = ib[1:0];
        exp = {ia > ib, ia < ib, ia == ib, 1'b1};
        step();
        chk($sformatf("exh_a%0d_b%0d", ia, ib), u_flags(), exp);
        chk($sformatf("onehot_a%0d_b%0d", ia, ib), {3'b000, $countones({u_gt, u_lt, u_eq}) == 1}, 4'b0001);
      end
    end

    // Hold: flags keep the last result while in_vld is low.
    ua = 2'd0; ub = 2'd2;
    step();
    chk("hold_compute", u_flags(), 4'b0101);
    in_vld = 1'b0;
    ua = 2'd3;
    step();
    chk("hold_cycle1", u_flags(), 4'b0100);
    step();
    chk("hold_cycle2", u_flags(), 4'b0100);

    // Reset mid-stream discards the in-flight equal compare.
    in_vld = 1'b1;
    ua = 2'd3; ub = 2'd1;
    step();
    chk("stream_0", u_flags(), 4'b1001);
    ua = 2'd1; ub = 2'd2;
    step();
    chk("stream_1", u_flags(), 4'b0101);
    rst_n = 1'b0;
    ua = 2'd1; ub = 2'd1;
    step();
    chk("midreset", u_flags(), 4'b0000);
    rst_n  = 1'b1;
    in_vld = 1'b0;
    step();
    chk("midreset_after", u_flags(), 4'b0000);

    // Signed 2-bit and unsigned 8-bit builds.
    in_vld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sa = s_a_tab[k]; sb = s_b_tab[k];
      wa = w_a_tab[k]; wb = w_b_tab[k];
      step();
      chk($sformatf("signed_%0d", k), {s_gt, s_lt, s_eq, s_vld}, s_e_tab[k]);
      chk($sformatf("wide_%0d", k), {w_gt, w_lt, w_eq, w_vld}, w_e_tab[k]);
    end

    in_vld = 1'b0;
    step();
    chk("wide_vld_drop", {w_gt, w_lt, w_eq, w_vld}, 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
